alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream driver for simple_alu.
- Accepts a parallel command {op, A, B} on a valid/ready interface and serialises it onto the ALU's three-cycle opcode_valid/opcode/data protocol.
- Waits for the ALU's done pulse, then returns {result, overflow} on a valid/ready response interface.
- A watchdog converts a missing done into a timeout response, so the host interface can never hang.

Parameters:
- DATA_WIDTH, 8, width of operands and result; must match simple_alu.
- TIMEOUT, 16, maximum WAIT_DONE cycles before a timeout response (>=2).
- CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 PAR, 11 COMP
- cmd_a  in  DATA_WIDTH  operand A
- cmd_b  in  DATA_WIDTH  operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_result  out  DATA_WIDTH  captured ALU result
- rsp_overflow  out  1  captured ALU overflow
- rsp_timeout  out  1  response is a watchdog timeout
- alu_opcode_valid  out  1  to simple_alu opcode_valid
- alu_opcode  out  1  to simple_alu opcode (serial)
- alu_data  out  DATA_WIDTH  to simple_alu data
- alu_done  in  1  from simple_alu done
- alu_result  in  DATA_WIDTH  from simple_alu result
- alu_overflow  in  1  from simple_alu overflow

Behaviour:
- Clock and reset: clk; reset_n is synchronous, active-low. All outputs are registered.
- Reset values: every output is 0, and the state is STARTUP.
- FSM states: STARTUP, IDLE, SEND_OP0, SEND_OP1A, SEND_B, WAIT_DONE, RESP.
- STARTUP:
  - Lasts exactly one cycle after reset_n rises, giving the ALU time to leave its RESET state.
  - cmd_ready=0 during this cycle; next state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: capture op, A and B into internal registers; next state is SEND_OP0.
- SEND_OP0: alu_opcode_valid=1, alu_opcode=op[0], alu_data=0.
- SEND_OP1A: alu_opcode_valid=1, alu_opcode=op[1], alu_data=A.
- SEND_B: alu_opcode_valid=1, alu_opcode=0, alu_data=B.
- Serialisation rules:
  - The three cycles above are strictly consecutive and are never stretched.
  - cmd_ready=0 from acceptance until the state returns to IDLE.
- WAIT_DONE:
  - alu_opcode_valid=0, alu_data=0.
  - The watchdog counter clears on entry and increments every cycle.
  - On alu_done=1: capture alu_result and alu_overflow the same cycle, set rsp_timeout=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no done: rsp_result=0, rsp_overflow=0, rsp_timeout=1, go to RESP.
  - If alu_done and the timeout occur in the same cycle, done wins and the response is a normal one.
- RESP:
  - rsp_valid=1; rsp_result, rsp_overflow and rsp_timeout stay stable until rsp_valid&&rsp_ready.
  - The cycle after the handshake: rsp_valid=0, next state is IDLE.
  - Minimum accept-to-accept spacing for back-to-back commands is 6 cycles (IDLE, 3 send cycles, at least 1 WAIT cycle, RESP).
- alu_done outside WAIT_DONE (late done after a timeout, or a spurious done) is ignored and produces no response.
- After a timeout the ALU state is undefined; recovery is by reset_n only. The sequencer still returns to IDLE and accepts new commands.
- Reset mid-operation: on the next edge, all outputs go to 0 and the state to STARTUP. Any in-flight command is discarded with no response.
- Arithmetic: none in this block; result width equals DATA_WIDTH and is passed through unmodified.

Decomposition:
- alu_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_PAR/OP_COMP (2 bits), shared with simple_alu;
  - the sequencer state enum;
  - DATA_WIDTH default.
- Single module; the watchdog counter is inline, with no sub-module.

Test Plan:
- Reset, then ADD A=8'h05 B=8'h03 -> alu_opcode sequence 0,0; alu_data 00,05,03; rsp_result=8'h08, overflow=0, timeout=0.
- ADD A=8'hFF B=8'h01 -> rsp_result=8'h00, rsp_overflow=1.
- PAR op=2'b10 -> alu_opcode sequence 0 then 1; cmd_ready=0 until the response completes.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and payload held stable, cmd_ready=0; accept on cycle 6 -> IDLE one cycle later.
- ALU model never asserts done -> rsp_valid=1 with rsp_timeout=1, rsp_result=0, after 16 WAIT_DONE cycles; a late alu_done afterwards is ignored.
- Assert reset_n=0 during SEND_OP1A -> all outputs 0 next edge, no response, cmd_ready=0 for the STARTUP cycle, then a fresh SUB 8'h09-8'h04 -> rsp_result=8'h05.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for simple_alu and its upstream command sequencer.
// Opcode encodings must stay in step with simple_alu's decoder.
package alu_pkg;

  // Default operand/result width shared by the ALU and the sequencer
  localparam int ALU_DATA_WIDTH = 8;

  // Two-bit opcodes, sent LSB first over the ALU's serial opcode line
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PAR  = 2'b10;
  localparam logic [1:0] OP_COMP = 2'b11;

  // Sequencer control states
  typedef enum logic [2:0] {
    STARTUP   = 3'd0,
    IDLE      = 3'd1,
    SEND_OP0  = 3'd2,
    SEND_OP1A = 3'd3,
    SEND_B    = 3'd4,
    WAIT_DONE = 3'd5,
    RESP      = 3'd6
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Upstream driver for simple_alu.
// Takes a parallel {op, A, B} command on a valid/ready port, plays it out
// over the ALU's three-beat opcode_valid/opcode/data protocol, waits for the
// ALU's done pulse and hands {result, overflow} back on a valid/ready
// response port. A watchdog turns a missing done into a timeout response so
// the host side can never lock up.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,

  // Host command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,

  // Host response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,

  // simple_alu side
  output logic                  alu_opcode_valid,
  output logic                  alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow
);

  // Last WAIT_DONE count before the watchdog gives up; WAIT_DONE therefore
  // lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e            state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [CNT_W-1:0]      wd_cnt;

  // Control FSM with all host- and ALU-facing outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= STARTUP;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      wd_cnt           <= '0;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_result       <= '0;
      rsp_overflow     <= 1'b0;
      rsp_timeout      <= 1'b0;
      alu_opcode_valid <= 1'b0;
      alu_opcode       <= 1'b0;
      alu_data         <= '0;
    end else begin
      case (state)
        // One idle cycle so the ALU can leave its own reset state first
        STARTUP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        // Latch the whole command; the host is free to change its inputs
        // while the operands are being serialised.
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q             <= cmd_op;
            a_q              <= cmd_a;
            b_q              <= cmd_b;
            cmd_ready        <= 1'b0;
            alu_opcode_valid <= 1'b1;
            alu_opcode       <= cmd_op[0];
            alu_data         <= '0;
            state            <= SEND_OP0;
          end
        end

        // Beat 1 on the wire: opcode bit 0, no data
        SEND_OP0: begin
          alu_opcode_valid <= 1'b1;
          alu_opcode       <= op_q[1];
          alu_data         <= a_q;
          state            <= SEND_OP1A;
        end

        // Beat 2 on the wire: opcode bit 1 together with operand A
        SEND_OP1A: begin
          alu_opcode_valid <= 1'b1;
          alu_opcode       <= 1'b0;
          alu_data         <= b_q;
          state            <= SEND_B;
        end

        // Beat 3 on the wire: operand B; arm the watchdog for the wait
        SEND_B: begin
          alu_opcode_valid <= 1'b0;
          alu_opcode       <= 1'b0;
          alu_data         <= '0;
          wd_cnt           <= '0;
          state            <= WAIT_DONE;
        end

        // done is checked before the watchdog so a done that lands on the
        // final count still yields a normal response.
        WAIT_DONE: begin
          if (alu_done) begin
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        // Payload is frozen until the host takes it. Any alu_done seen here
        // (a late one after a timeout) is simply not looked at.
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        // Unused encoding: park safely in IDLE with the ALU lines quiet
        default: begin
          state            <= IDLE;
          cmd_ready        <= 1'b1;
          rsp_valid        <= 1'b0;
          alu_opcode_valid <= 1'b0;
          alu_opcode       <= 1'b0;
          alu_data         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer.
// A small behavioural ALU answers the serial protocol after a chosen number
// of WAIT cycles; expected beats, response latency and payload are derived
// from the command and that latency with plain arithmetic.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;
  logic          alu_opcode_valid;
  logic          alu_opcode;
  logic [DW-1:0] alu_data;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic          alu_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
    .alu_opcode_valid(alu_opcode_valid), .alu_opcode(alu_opcode),
    .alu_data(alu_data), .alu_done(alu_done), .alu_result(alu_result),
    .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to measure accept-to-accept spacing
  always @(posedge clk) cyc++;

  // Reference ALU behaviour: {overflow, result}
  function automatic logic [DW:0] aluFn(input logic [1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_PAR:  r = {1'b0, {(DW-1){1'b0}}, ^{a, b}};
      default: r = {(a == b), ((a > b) ? a : b)};
    endcase
    return r;
  endfunction

  // Behavioural ALU: collects three beats, answers alu_latency cycles into WAIT
  int            alu_latency = 0;
  logic          stub_done = 1'b0;
  logic          spurious_done = 1'b0;
  logic [DW-1:0] stub_result = '0;
  logic          stub_ovf = 1'b0;
  int            beat = 0;
  bit            pend = 1'b0;
  int            pend_cnt = 0;
  logic [1:0]    s_op = 2'b00;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;

  assign alu_done     = stub_done | spurious_done;
  assign alu_result   = stub_result;
  assign alu_overflow = stub_ovf;

  always @(posedge clk) begin
    stub_done   <= 1'b0;
    stub_result <= DW'($urandom);
    stub_ovf    <= 1'($urandom);
    if (!reset_n) begin
      beat = 0;
      pend = 1'b0;
    end else begin
      if (alu_opcode_valid) begin
        case (beat)
          0: s_op[0] = alu_opcode;
          1: begin s_op[1] = alu_opcode; s_a = alu_data; end
          default: begin s_b = alu_data; pend = 1'b1; pend_cnt = alu_latency; end
        endcase
        beat = (beat == 2) ? 0 : beat + 1;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          pend = 1'b0;
          stub_done <= 1'b1;
          {stub_ovf, stub_result} <= aluFn(s_op, s_a, s_b);
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // Absolute guard in case something escapes the bounded loops
  initial begin
    #1000000;
    $display("[TB] FAIL global_watchdog: got no finish, expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    checkOutput({tag, "_rsp_overflow"}, 32'(rsp_overflow), 32'd0);
    checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    checkOutput({tag, "_alu_opcode_valid"}, 32'(alu_opcode_valid), 32'd0);
    checkOutput({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    checkOutput({tag, "_alu_data"}, 32'(alu_data), 32'd0);
  endtask

  // One full command: accept, three beats, wait, response held for 'hold' cycles
  task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input int lat, input int hold,
                               input bit use_ref, input logic [DW:0] ref_val);
    int          n;
    int          waited;
    int          exp_n;
    bit          exp_to;
    logic [DW:0] exp;
    exp_to = (lat > TO - 1);
    exp    = exp_to ? '0 : (use_ref ? ref_val : aluFn(op, a, b));
    exp_n  = 5 + ((lat < TO - 1) ? lat : TO - 1);
    alu_latency = lat;

    waited = 0;
    while (!cmd_ready && waited < 20) begin step(); waited++; end
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    last_accept = cyc;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = DW'($urandom); cmd_b = DW'($urandom);

    checkOutput("op0_valid", 32'(alu_opcode_valid), 32'd1);
    checkOutput("op0_opcode", 32'(alu_opcode), 32'(op[0]));
    checkOutput("op0_data", 32'(alu_data), 32'd0);
    checkOutput("op0_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    checkOutput("op1a_valid", 32'(alu_opcode_valid), 32'd1);
    checkOutput("op1a_opcode", 32'(alu_opcode), 32'(op[1]));
    checkOutput("op1a_data", 32'(alu_data), 32'(a));
    checkOutput("op1a_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    checkOutput("b_valid", 32'(alu_opcode_valid), 32'd1);
    checkOutput("b_opcode", 32'(alu_opcode), 32'd0);
    checkOutput("b_data", 32'(alu_data), 32'(b));
    checkOutput("b_cmd_ready", 32'(cmd_ready), 32'd0);

    n = 3;
    do begin
      step();
      n++;
      if (!rsp_valid) begin
        checkOutput("wait_valid", 32'(alu_opcode_valid), 32'd0);
        checkOutput("wait_data", 32'(alu_data), 32'd0);
        checkOutput("wait_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end while (!rsp_valid && n < 40);

    checkOutput("rsp_latency", 32'(n), 32'(exp_n));
    checkOutput("rsp_result", 32'(rsp_result), 32'(exp[DW-1:0]));
    checkOutput("rsp_overflow", 32'(rsp_overflow), 32'(exp[DW]));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    checkOutput("rsp_cmd_ready", 32'(cmd_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_result", 32'(rsp_result), 32'(exp[DW-1:0]));
      checkOutput("hold_overflow", 32'(rsp_overflow), 32'(exp[DW]));
      checkOutput("hold_timeout", 32'(rsp_timeout), 32'(exp_to));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int first_accept;
    logic [DW-1:0] ra;

    $display("[TB] start");

    // Power-on reset
    reset_n = 1'b0;
    repeat (3) step();
    checkAllZero("reset");
    reset_n = 1'b1;
    checkOutput("startup_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Directed cases
    applyStimulus(OP_ADD, 8'h05, 8'h03, 2, 0, 1'b1, 9'h008);
    applyStimulus(OP_ADD, 8'hFF, 8'h01, 1, 0, 1'b1, 9'h100);
    applyStimulus(OP_PAR, DW'($urandom), DW'($urandom), 3, 0, 1'b0, '0);
    applyStimulus(OP_SUB, DW'($urandom), DW'($urandom), 3, 5, 1'b0, '0);

    // Back-to-back commands at the minimum spacing
    applyStimulus(OP_ADD, DW'($urandom), DW'($urandom), 0, 0, 1'b0, '0);
    first_accept = last_accept;
    applyStimulus(OP_COMP, DW'($urandom), DW'($urandom), 0, 0, 1'b0, '0);
    checkOutput("accept_spacing", 32'(last_accept - first_accept), 32'd6);

    // done on the very last watchdog cycle still gives a normal response
    applyStimulus(OP_SUB, DW'($urandom), DW'($urandom), TO - 1, 0, 1'b0, '0);

    // Missing done: timeout, with the late done arriving while held in RESP
    applyStimulus(OP_ADD, DW'($urandom), DW'($urandom), TO + 4, 6, 1'b0, '0);
    repeat (3) begin
      step();
      checkOutput("late_done_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Spurious done in IDLE is ignored
    spurious_done = 1'b1;
    step();
    spurious_done = 1'b0;
    step();
    checkOutput("spurious_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("spurious_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomised commands, latencies straddling the watchdog limit
    for (int k = 0; k < 24; k++) begin
      applyStimulus(2'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 18)), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    // Reset while operand A is on the wire
    ra = DW'($urandom);
    cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_a = ra; cmd_b = DW'($urandom);
    step();
    cmd_valid = 1'b0;
    step();
    checkOutput("midop_op1a_data", 32'(alu_data), 32'(ra));
    reset_n = 1'b0;
    step();
    checkAllZero("midop_reset");
    reset_n = 1'b1;
    checkOutput("midop_startup_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    checkOutput("midop_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midop_no_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(OP_SUB, 8'h09, 8'h04, 1, 0, 1'b1, 9'h005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
